// File: rtl/ysyx_22041412_bpu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_bpu_pkg
// Shared definitions for the branch predictor: the B-type opcode, the 2-bit
// saturating counter type, the predictor state enum, the B-type immediate
// decoder and the counter update rule.
// ---------------------------------------------------------------------------
package ysyx_22041412_bpu_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef logic [1:0] cnt2_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // B-type immediate, 13 bits with the implicit zero LSB; the caller
    // sign-extends it to the PC width.
    function automatic logic [12:0] imm_b(input logic [31:0] inst);
        logic unused_fields;
        unused_fields = ^{inst[24:12], inst[6:0]};
        return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Saturating step: taken counts up to 3, not-taken counts down to 0.
    function automatic cnt2_t cnt_step(input cnt2_t cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_22041412_bpu_table.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_bpu_table
// Direct-mapped table of 2-bit counters with a tag/valid BTB per entry, plus
// the pointer that sweeps the table clear after reset or flush.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset (pointer only)
//   init_en_i        predictor is in INIT: write one entry per cycle
//   restart_i        flush accepted: rewind the sweep pointer to 0
//   init_last_o      the sweep is writing the final entry this cycle
//   rd_idx_i/tag_i   lookup index and tag
//   rd_hit_o         entry valid with a matching tag (write-first)
//   rd_cnt_o         entry counter (write-first)
//   wr_en_i          apply a resolved branch outcome this cycle
//   wr_idx_i/tag_i   update index and tag
//   wr_taken_i       resolved direction
// ---------------------------------------------------------------------------
module ysyx_22041412_bpu_table
    import ysyx_22041412_bpu_pkg::*;
#(
    parameter int    IDX_W    = 6,
    parameter int    TAG_W    = 8,
    parameter cnt2_t CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_en_i,
    input  logic             restart_i,
    output logic             init_last_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_hit_o,
    output cnt2_t            rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_taken_i
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    cnt2_t            cnt_mem   [DEPTH];
    logic [TAG_W-1:0] tag_mem   [DEPTH];
    logic             valid_mem [DEPTH];

    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic  wr_alias;
    cnt2_t wr_cnt;
    logic  rd_bypass;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        ptr_d = ptr_q;
        if (restart_i) begin
            ptr_d = '0;
        end else if (init_en_i) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end

    assign init_last_o = init_en_i && (ptr_q == '1);

    // A valid entry owned by another tag is not trained further: the new
    // owner starts from a weak state in its own direction.
    always_comb begin
        wr_alias = valid_mem[wr_idx_i] && (tag_mem[wr_idx_i] != wr_tag_i);
        wr_cnt   = cnt_step(cnt_mem[wr_idx_i], wr_taken_i);
        if (wr_alias) begin
            wr_cnt = wr_taken_i ? 2'b10 : 2'b01;
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is forwarded,
    // so the lookup sees the post-update tag (now valid) and counter.
    always_comb begin
        rd_bypass = wr_en_i && (wr_idx_i == rd_idx_i);
        rd_hit_o  = valid_mem[rd_idx_i] && (tag_mem[rd_idx_i] == rd_tag_i);
        rd_cnt_o  = cnt_mem[rd_idx_i];
        if (rd_bypass) begin
            rd_hit_o = (wr_tag_i == rd_tag_i);
            rd_cnt_o = wr_cnt;
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: the arrays have no reset; the INIT sweep clears them one entry per cycle, which keeps them mappable to RAM.
    always_ff @(posedge clk) begin
        if (init_en_i) begin
            cnt_mem[ptr_q]   <= CNT_INIT;
            valid_mem[ptr_q] <= 1'b0;
        end else if (wr_en_i) begin
            cnt_mem[wr_idx_i]   <= wr_cnt;
            tag_mem[wr_idx_i]   <= wr_tag_i;
            valid_mem[wr_idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22041412_bpu.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_bpu
// Branch predictor for the IFU. B-type instructions are predicted from a
// 2-bit counter when the tagged BTB hits, otherwise by the static
// backward-taken rule; everything else predicts fall-through. Predictions
// are registered one cycle after an accepted lookup. Resolved branches train
// the table and feed the hit/miss performance counters.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush_i           re-initialise the table (one-cycle pulse)
//   lk_valid_i        lookup request; lk_ready_o high when accepted (RUN)
//   lk_pc_i           PC of the fetched instruction
//   lk_inst_i         raw instruction word
//   pred_valid_o      one-cycle pulse per accepted lookup
//   pred_taken_o      predicted direction
//   pred_target_o     predicted next PC
//   upd_valid_i       resolved conditional branch
//   upd_pc_i          branch PC
//   upd_taken_i       resolved direction
//   upd_target_i      resolved taken target (not stored; imm is authoritative)
//   upd_pred_i        direction that was predicted for this branch
//   pred_hit_cnt_o    correct predictions (wraps)
//   pred_miss_cnt_o   mispredictions (wraps)
// ---------------------------------------------------------------------------
module ysyx_22041412_bpu
    import ysyx_22041412_bpu_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          IDX_W    = 6,
    parameter int          TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              lk_valid_i,
    output logic              lk_ready_o,
    input  logic [ADDR_W-1:0] lk_pc_i,
    input  logic [31:0]       lk_inst_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_i,
    output logic [63:0]       pred_hit_cnt_o,
    output logic [63:0]       pred_miss_cnt_o
);

    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    state_e            state_q, state_d;
    logic              lk_ready_q, lk_ready_d;
    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [ADDR_W-1:0] pred_target_q, pred_target_d;
    logic [63:0]       hit_cnt_q, hit_cnt_d;
    logic [63:0]       miss_cnt_q, miss_cnt_d;

    logic              init_en;
    logic              restart;
    logic              init_last;
    logic              rd_hit;
    cnt2_t             rd_cnt;
    logic              wr_en;

    logic              lk_fire;
    logic              upd_fire;
    logic              is_branch;
    logic [12:0]       imm;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] seq_pc;
    logic              br_dir;

    logic              unused_upd;
    assign unused_upd = ^{upd_target_i, upd_pc_i[1:0], upd_pc_i[ADDR_W-1:TAG_HI+1]};

    assign init_en  = (state_q == INIT);
    assign lk_fire  = (state_q == RUN) && lk_valid_i;
    assign upd_fire = (state_q == RUN) && upd_valid_i;
    assign restart  = (state_q == RUN) && flush_i;
    // A flush drops the table write but the outcome is still counted.
    assign wr_en    = upd_fire && !flush_i;

    ysyx_22041412_bpu_table #(
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .CNT_INIT (CNT_INIT)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .init_en_i   (init_en),
        .restart_i   (restart),
        .init_last_o (init_last),
        .rd_idx_i    (lk_pc_i[IDX_W+1:2]),
        .rd_tag_i    (lk_pc_i[TAG_HI:TAG_LO]),
        .rd_hit_o    (rd_hit),
        .rd_cnt_o    (rd_cnt),
        .wr_en_i     (wr_en),
        .wr_idx_i    (upd_pc_i[IDX_W+1:2]),
        .wr_tag_i    (upd_pc_i[TAG_HI:TAG_LO]),
        .wr_taken_i  (upd_taken_i)
    );

    always_comb begin
        is_branch = (lk_inst_i[6:0] == OPC_BRANCH);
        imm       = imm_b(lk_inst_i);
        br_target = lk_pc_i + {{(ADDR_W-13){imm[12]}}, imm};
        seq_pc    = lk_pc_i + ADDR_W'(4);
        // BTB miss: backward branches (loops) are guessed taken.
        br_dir    = rd_hit ? rd_cnt[1] : (br_target < lk_pc_i);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (init_last) state_d = RUN;
            RUN:     if (flush_i)   state_d = INIT;
            default: state_d = INIT;
        endcase

        lk_ready_d    = (state_d == RUN);
        pred_valid_d  = lk_fire;
        pred_taken_d  = lk_fire && is_branch && br_dir;
        pred_target_d = '0;
        if (lk_fire) begin
            pred_target_d = pred_taken_d ? br_target : seq_pc;
        end

        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd_fire) begin
            if (upd_pred_i == upd_taken_i) begin
                hit_cnt_d = hit_cnt_q + 64'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= INIT;
            lk_ready_q    <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            lk_ready_q    <= lk_ready_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign lk_ready_o      = lk_ready_q;
    assign pred_valid_o    = pred_valid_q;
    assign pred_taken_o    = pred_taken_q;
    assign pred_target_o   = pred_target_q;
    assign pred_hit_cnt_o  = hit_cnt_q;
    assign pred_miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_22041412_bpu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041412_bpu
// Directed bench for the branch predictor. Instruction words used:
//   0x00000013  addi x0,x0,0          (not a branch)
//   0xFE0018E3  bne  x0,x0,-16
//   0x00001863  bne  x0,x0,+16
//   0x00001463  bne  x0,x0,+8
// PC index is pc[7:2], tag is pc[15:8].
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_bpu;

    localparam logic [31:0] I_NOP = 32'h0000_0013;
    localparam logic [31:0] I_BM16 = 32'hFE00_18E3;
    localparam logic [31:0] I_BP16 = 32'h0000_1863;
    localparam logic [31:0] I_BP8  = 32'h0000_1463;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        lk_valid_i;
    logic        lk_ready_o;
    logic [31:0] lk_pc_i;
    logic [31:0] lk_inst_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_i;
    logic [63:0] pred_hit_cnt_o;
    logic [63:0] pred_miss_cnt_o;

    int total = 0;
    int bad   = 0;
    int n_low;
    logic saw_pv;

    always #5 clk = ~clk;

    ysyx_22041412_bpu dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .lk_valid_i      (lk_valid_i),
        .lk_ready_o      (lk_ready_o),
        .lk_pc_i         (lk_pc_i),
        .lk_inst_i       (lk_inst_i),
        .pred_valid_o    (pred_valid_o),
        .pred_taken_o    (pred_taken_o),
        .pred_target_o   (pred_target_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .upd_target_i    (upd_target_i),
        .upd_pred_i      (upd_pred_i),
        .pred_hit_cnt_o  (pred_hit_cnt_o),
        .pred_miss_cnt_o (pred_miss_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pred(input string tag, input logic v, input logic t, input logic [31:0] tgt);
        check({tag, ".valid"},  64'(pred_valid_o),  64'(v));
        check({tag, ".taken"},  64'(pred_taken_o),  64'(t));
        check({tag, ".target"}, 64'(pred_target_o), 64'(tgt));
    endtask

    task automatic check_cnt(input string tag, input int hit, input int miss);
        check({tag, ".hit"},  pred_hit_cnt_o,  64'(hit));
        check({tag, ".miss"}, pred_miss_cnt_o, 64'(miss));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lk(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        lk_valid_i = v;
        lk_pc_i    = pc;
        lk_inst_i  = inst;
    endtask

    task automatic drive_upd(input logic v, input logic [31:0] pc, input logic t, input logic p);
        upd_valid_i  = v;
        upd_pc_i     = pc;
        upd_taken_i  = t;
        upd_pred_i   = p;
        upd_target_i = pc + 32'h8;
    endtask

    // Counts cycles with lk_ready_o low (bounded) and notes any prediction
    // produced meanwhile.
    task automatic wait_ready();
        n_low  = 0;
        saw_pv = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (lk_ready_o) break;
            n_low++;
            tick();
            if (pred_valid_o) saw_pv = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        flush_i = 1'b0;
        drive_lk(1'b1, 32'h8000_0000, I_NOP);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst.ready", 64'(lk_ready_o), 64'd0);
        check_pred("rst", 1'b0, 1'b0, 32'h0);
        check_cnt("rst", 0, 0);

        // Init sweep with a lookup held high
        rst = 1'b1;
        wait_ready();
        check("init.low_cycles", 64'(n_low), 64'd64);
        check("init.no_pred", 64'(saw_pv), 64'd0);
        check("init.ready", 64'(lk_ready_o), 64'd1);
        tick();
        check_pred("first_nonbr", 1'b1, 1'b0, 32'h8000_0004);

        // Static backward-taken fallback
        drive_lk(1'b1, 32'h8000_0010, I_BM16);
        tick();
        check_pred("static_bwd", 1'b1, 1'b1, 32'h8000_0000);
        drive_lk(1'b1, 32'h8000_0010, I_BP16);
        tick();
        check_pred("static_fwd", 1'b1, 1'b0, 32'h8000_0014);
        drive_lk(1'b0, 32'h0, I_NOP);
        tick();
        check("idle.valid", 64'(pred_valid_o), 64'd0);

        // Training idx 0, tag 01: 01 -> 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 4; i++) begin
            drive_upd(1'b1, 32'h8000_0100, 1'b1, 1'b0);
            tick();
        end
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        drive_lk(1'b1, 32'h8000_0100, I_BP8);
        tick();
        check_pred("trained", 1'b1, 1'b1, 32'h8000_0108);
        check_cnt("trained", 0, 4);

        // Saturation on idx 0x11: 4 taken -> 3, one not-taken -> 2
        drive_lk(1'b0, 32'h0, I_NOP);
        for (int i = 0; i < 4; i++) begin
            drive_upd(1'b1, 32'h8000_0044, 1'b1, 1'b1);
            tick();
        end
        drive_upd(1'b1, 32'h8000_0044, 1'b0, 1'b1);
        tick();
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        drive_lk(1'b1, 32'h8000_0044, I_BP16);
        tick();
        check_pred("sat_dec", 1'b1, 1'b1, 32'h8000_0054);
        check_cnt("sat_dec", 4, 5);

        // Aliasing tag 0x10 onto idx 0x11 with not-taken -> counter 01
        drive_lk(1'b0, 32'h0, I_NOP);
        drive_upd(1'b1, 32'h8000_1044, 1'b0, 1'b0);
        tick();
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        drive_lk(1'b1, 32'h8000_1044, I_BP16);
        tick();
        check_pred("alias_new_tag", 1'b1, 1'b0, 32'h8000_1048);
        drive_lk(1'b1, 32'h8000_0044, I_BM16);
        tick();
        check_pred("alias_old_tag", 1'b1, 1'b1, 32'h8000_0034);

        // Aliasing idx 0 (counter 3) with tag 02: taken -> 10, not-taken -> 01
        drive_lk(1'b0, 32'h0, I_NOP);
        drive_upd(1'b1, 32'h8000_0200, 1'b1, 1'b1);
        tick();
        drive_upd(1'b1, 32'h8000_0200, 1'b0, 1'b1);
        tick();
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        drive_lk(1'b1, 32'h8000_0200, I_BP8);
        tick();
        check_pred("alias_replace", 1'b1, 1'b0, 32'h8000_0204);
        check_cnt("alias_replace", 6, 6);

        // Same-cycle lookup and not-taken update on idx 0x20 at counter 2
        drive_lk(1'b0, 32'h0, I_NOP);
        drive_upd(1'b1, 32'h8000_0080, 1'b1, 1'b1);
        tick();
        drive_upd(1'b1, 32'h8000_0080, 1'b0, 1'b0);
        drive_lk(1'b1, 32'h8000_0080, I_BM16);
        tick();
        check_pred("bypass", 1'b1, 1'b0, 32'h8000_0084);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_pred("after_bypass", 1'b1, 1'b0, 32'h8000_0084);

        // Push idx 0 back to tag 01, counter 3, ahead of the flush
        drive_lk(1'b0, 32'h0, I_NOP);
        drive_upd(1'b1, 32'h8000_0100, 1'b1, 1'b1);
        tick();
        tick();
        check_cnt("pre_flush", 10, 6);

        // Flush with concurrent update and lookup
        flush_i = 1'b1;
        drive_upd(1'b1, 32'h8000_0080, 1'b1, 1'b1);
        drive_lk(1'b1, 32'h8000_0080, I_BM16);
        tick();
        flush_i = 1'b0;
        check_pred("flush_lookup", 1'b1, 1'b0, 32'h8000_0084);
        check("flush.ready", 64'(lk_ready_o), 64'd0);
        check_cnt("flush", 11, 6);

        // Updates during INIT must be ignored
        drive_upd(1'b1, 32'h8000_0080, 1'b1, 1'b0);
        wait_ready();
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        check("reinit.low_cycles", 64'(n_low), 64'd64);
        check("reinit.no_pred", 64'(saw_pv), 64'd0);
        check_cnt("reinit_hold", 11, 6);

        // BTB invalid again: static rule everywhere
        tick();
        check_pred("post_flush_bwd", 1'b1, 1'b1, 32'h8000_0070);
        drive_lk(1'b1, 32'h8000_0100, I_BP8);
        tick();
        check_pred("post_flush_fwd", 1'b1, 1'b0, 32'h8000_0104);

        // Counter back at 01: one not-taken update keeps it not-taken
        drive_lk(1'b0, 32'h0, I_NOP);
        drive_upd(1'b1, 32'h8000_0100, 1'b0, 1'b1);
        tick();
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        drive_lk(1'b1, 32'h8000_0100, I_BP8);
        tick();
        check_pred("post_flush_cnt", 1'b1, 1'b0, 32'h8000_0104);
        check_cnt("final", 11, 7);

        drive_lk(1'b0, 32'h0, I_NOP);
        tick();
        check("end.idle", 64'(pred_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041412_bpu.md
Name: ysyx_22041412_bpu

Overview:
- Parametrised branch predictor serving the IFU; replaces the fixed "backward-taken" static rule with a direct-mapped table of 2-bit saturating counters plus a tagged BTB.
- Static backward-taken remains the fallback on a BTB miss.
- The IFU issues a lookup per fetched instruction and receives a registered prediction one cycle later.
- The resolve stage writes back each conditional-branch outcome; the block keeps hit/miss performance counters.

Parameters:
- ADDR_W, 32: PC and target width.
- IDX_W, 6: index bits; table depth = 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, 8: BTB tag bits, taken from pc[IDX_W+TAG_W+1:IDX_W+2].
- CNT_INIT, 2'b01: counter value written on init (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush_i  in  1  re-initialise the table (fence.i or context change); one-cycle pulse.
- lk_valid_i  in  1  lookup request.
- lk_ready_o  out  1  lookup accepted; low during INIT.
- lk_pc_i  in  ADDR_W  PC of the instruction.
- lk_inst_i  in  32  raw instruction word, used for B-type detection and immediate extraction.
- pred_valid_o  out  1  prediction valid; one cycle after an accepted lookup.
- pred_taken_o  out  1  predicted direction.
- pred_target_o  out  ADDR_W  predicted next PC.
- upd_valid_i  in  1  resolved conditional branch.
- upd_pc_i  in  ADDR_W  branch PC.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_pred_i  in  1  direction that was predicted for this branch.
- pred_hit_cnt_o  out  64  count of correct predictions.
- pred_miss_cnt_o  out  64  count of mispredictions.

Behaviour:
- Reset (rst low, asynchronous):
  - State = INIT, init pointer = 0.
  - All outputs 0; both performance counters 0.
  - Table arrays are not reset by flops; they are cleared by the INIT sweep.
- State machine:
  - INIT: one entry per cycle, counter = CNT_INIT, BTB valid = 0. lk_ready_o = 0; updates are ignored. After entry 2**IDX_W-1, go to RUN. Total duration is exactly 2**IDX_W cycles.
  - RUN: lk_ready_o = 1. flush_i moves to INIT with pointer = 0 next cycle. A lookup in the flush cycle is still answered.
- Lookup (RUN, lk_valid_i high):
  - Non-B-type (opcode != 1100011): next cycle pred_valid_o = 1, pred_taken_o = 0, pred_target_o = lk_pc_i + 4.
  - B-type: compute imm_b target = lk_pc_i + sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
    - BTB hit (valid and tag match): direction = counter[1].
    - BTB miss: direction = (target < lk_pc_i), unsigned compare (static backward-taken).
    - pred_target_o = direction ? imm target : pc + 4. The BTB target is used only as a consistency source; the decoded immediate is authoritative.
  - All additions wrap modulo 2**ADDR_W.
- Output timing: prediction outputs are registered. pred_valid_o is a one-cycle pulse per accepted lookup, and goes low the cycle after a non-requesting cycle.
- Update (RUN, upd_valid_i high), written at the clock edge:
  - Counter saturates: taken increments with max 3; not-taken decrements with min 0.
  - BTB entry set valid with the new tag. On a tag mismatch, the counter is replaced with taken ? 2'b10 : 2'b01.
  - upd_pred_i == upd_taken_i increments pred_hit_cnt_o; otherwise pred_miss_cnt_o increments.
  - Both performance counters wrap at 2**64.
- Lookup and update to the same index in the same cycle: lookup sees the post-update counter and tag (write-first bypass).
- flush_i together with upd_valid_i: the update is dropped, but the performance counters still count it.
- pred_valid_o is 0 in every INIT cycle.

Decomposition:
- Shared package ysyx_22041412_bpu_pkg:
  - opcode constant OPC_BRANCH = 7'b1100011;
  - counter typedef cnt2_t;
  - state enum {INIT, RUN};
  - function imm_b(inst).
- One sub-module, ysyx_22041412_bpu_table:
  - Holds the counter and tag/valid arrays, sized by IDX_W and TAG_W.
  - One read port with write-first bypass; one write port.
  - Also owns the init sweep pointer.

Test Plan:
- Init: release rst, hold lk_valid_i = 1. Expect lk_ready_o = 0 for exactly 64 cycles, then 1. The first prediction follows one cycle after lk_ready_o rises.
- Static fallback: lookup pc = 0x80000010 with bne imm = -16. Expect pred_taken_o = 1, target 0x80000000. Repeat with imm = +16: expect taken = 0, target 0x80000014.
- Training: four updates of pc 0x80000100 with taken = 1, upd_pred_i = 0, forward imm = +8. Then lookup: expect taken = 1, target 0x80000108. pred_miss_cnt_o = 4.
- Saturation and aliasing: train an index to 3 with four taken updates, then one not-taken. Expect counter = 2 and still taken. An update from a different tag at the same index resets the counter to 01, so predict not-taken.
- Same-cycle collision: lookup and update (not-taken) of the same pc with counter at 2. Expect the prediction to reflect counter 1, i.e. not-taken.
- Flush mid-run: assert flush_i with a concurrent update. Expect 64 INIT cycles with the update discarded; pred_hit_cnt_o/pred_miss_cnt_o still increment and then hold; the table returns to CNT_INIT with BTB invalid.
